// File: rtl/roce_req_gen.sv
// roce_req_gen: RDMA READ/WRITE work-request generator for the user kernel.
// Issues tx_meta requests, tracks in-flight credits via tx_status, keeps run stats.
module roce_req_gen #(
    parameter int unsigned META_W          = 256,
    parameter int unsigned STATUS_W        = 512,
    parameter int unsigned ADDR_W          = 48,
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned ADDR_WINDOW     = 4194304,
    parameter int unsigned RUN_CYCLES      = 1250000000
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_idle,
    output logic                  ap_done,
    output logic                  ap_ready,
    input  logic [2:0]            cfg_op,
    input  logic [23:0]           cfg_qpn,
    input  logic [4:0]            cfg_len_log2,
    input  logic [31:0]           cfg_num_req,
    input  logic [ADDR_W-1:0]     cfg_laddr_base,
    input  logic [ADDR_W-1:0]     cfg_raddr_base,
    output logic                  m_axis_tx_meta_tvalid,
    input  logic                  m_axis_tx_meta_tready,
    output logic [META_W-1:0]     m_axis_tx_meta_tdata,
    output logic [META_W/8-1:0]   m_axis_tx_meta_tkeep,
    output logic                  m_axis_tx_meta_tlast,
    input  logic                  s_axis_tx_status_tvalid,
    output logic                  s_axis_tx_status_tready,
    input  logic [STATUS_W-1:0]   s_axis_tx_status_tdata,
    output logic [31:0]           stat_sent,
    output logic [31:0]           stat_acked,
    output logic [31:0]           stat_cycles,
    output logic                  stat_timeout,
    output logic                  stat_spurious
);

    localparam int unsigned LA_LSB  = 27;
    localparam int unsigned RA_LSB  = 27 + ADDR_W;
    localparam int unsigned LEN_LSB = 27 + 2 * ADDR_W;
    localparam logic [7:0]  MAX8    = 8'(MAX_OUTSTANDING);
    localparam logic [63:0] WIN64   = 64'(ADDR_WINDOW);
    localparam logic [32:0] RUN33   = 33'(RUN_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                start_q;
    logic [2:0]          op_q;
    logic [23:0]         qpn_q;
    logic [31:0]         len_q;
    logic [31:0]         num_q;
    logic [ADDR_W-1:0]   lbase_q, rbase_q;
    logic [ADDR_W-1:0]   off_q, off_d;
    logic [7:0]          outst_q;
    logic                tvalid_q;
    logic [META_W-1:0]   tdata_q, tdata_d;
    logic [31:0]         sent_q, acked_q, cycles_q;
    logic                timeout_q, spurious_q;

    logic                start_edge, accept, sts, active;
    logic                to_hit, stop, quota_left, can_issue, ack_ok;
    logic [63:0]         nxt64;
    logic                unused_status;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign unused_status = ^s_axis_tx_status_tdata;

    assign start_edge = ap_start & ~start_q;
    assign accept     = tvalid_q & m_axis_tx_meta_tready;
    assign sts        = s_axis_tx_status_tvalid;
    assign ack_ok     = sts && (outst_q != 8'd0);
    assign active     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign to_hit     = (RUN_CYCLES != 0) && active &&
                        (({1'b0, cycles_q} + 33'd1) >= RUN33);
    assign stop       = timeout_q | to_hit;
    assign quota_left = (num_q == 32'd0) || (sent_q < num_q);
    assign can_issue  = (state_q == S_ISSUE) && !tvalid_q && !stop &&
                        (outst_q < MAX8) && quota_left;

    // Next address offset: step by len, restart at 0 when the next request would leave the window
    always_comb begin
        nxt64 = 64'(off_q) + 64'(len_q);
        off_d = nxt64[ADDR_W-1:0];
        if ((64'(len_q) > WIN64) || ((nxt64 + 64'(len_q)) > WIN64)) begin
            off_d = '0;
        end
    end

    // Request descriptor assembled from the latched configuration and current offset
    always_comb begin
        tdata_d = '0;
        tdata_d[2:0]                = op_q;
        tdata_d[26:3]               = qpn_q;
        tdata_d[LA_LSB +: ADDR_W]   = lbase_q + off_q;
        tdata_d[RA_LSB +: ADDR_W]   = rbase_q + off_q;
        tdata_d[LEN_LSB +: 32]      = len_q;
    end

    // Control FSM next state; a timeout waits only for a pending beat to be accepted
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_edge) state_d = S_ISSUE;
            S_ISSUE: begin
                if (stop) begin
                    if (!tvalid_q || accept) state_d = S_DONE;
                end else if ((num_q != 32'd0) && (sent_q >= num_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (stop || (outst_q == 8'd0)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Config latch, run statistics and address offset
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            start_q    <= 1'b0;
            op_q       <= '0;
            qpn_q      <= '0;
            len_q      <= '0;
            num_q      <= '0;
            lbase_q    <= '0;
            rbase_q    <= '0;
            off_q      <= '0;
            sent_q     <= '0;
            acked_q    <= '0;
            cycles_q   <= '0;
            timeout_q  <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            start_q <= ap_start;
            if ((state_q == S_IDLE) && start_edge) begin
                op_q       <= cfg_op;
                qpn_q      <= cfg_qpn;
                len_q      <= 32'd1 << cfg_len_log2;
                num_q      <= cfg_num_req;
                lbase_q    <= cfg_laddr_base;
                rbase_q    <= cfg_raddr_base;
                off_q      <= '0;
                sent_q     <= '0;
                acked_q    <= '0;
                cycles_q   <= '0;
                timeout_q  <= 1'b0;
                spurious_q <= 1'b0;
            end else begin
                if (active) cycles_q <= sat_inc(cycles_q);
                if (to_hit) timeout_q <= 1'b1;
                if (accept) begin
                    sent_q <= sat_inc(sent_q);
                    off_q  <= off_d;
                end
                if (ack_ok)           acked_q    <= sat_inc(acked_q);
                else if (sts)         spurious_q <= 1'b1;
            end
        end
    end

    // In-flight credit counter; simultaneous issue and completion cancel out
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            outst_q <= '0;
        end else if (accept && !ack_ok) begin
            outst_q <= outst_q + 8'd1;
        end else if (ack_ok && !accept) begin
            outst_q <= outst_q - 8'd1;
        end
    end

    // Meta beat register: load on issue, hold under backpressure, drop after accept
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
        end else if (can_issue) begin
            tvalid_q <= 1'b1;
            tdata_q  <= tdata_d;
        end else if (accept) begin
            tvalid_q <= 1'b0;
        end
    end

    assign ap_done  = (state_q == S_DONE);
    assign ap_ready = ap_done;
    assign ap_idle  = (state_q == S_IDLE) || (state_q == S_DONE);

    assign m_axis_tx_meta_tvalid   = tvalid_q;
    assign m_axis_tx_meta_tdata    = tdata_q;
    assign m_axis_tx_meta_tkeep    = '1;
    assign m_axis_tx_meta_tlast    = 1'b1;
    assign s_axis_tx_status_tready = 1'b1;

    assign stat_sent     = sent_q;
    assign stat_acked    = acked_q;
    assign stat_cycles   = cycles_q;
    assign stat_timeout  = timeout_q;
    assign stat_spurious = spurious_q;

endmodule

// File: tb/tb_roce_req_gen.sv
// tb_roce_req_gen: directed bench for roce_req_gen.
// Small window / credit / timeout parameters so every scenario fits one instance.
module tb_roce_req_gen;

    localparam int MW = 256;
    localparam int SW = 512;
    localparam int AW = 48;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ap_start, ap_idle, ap_done, ap_ready;
    logic [2:0]    cfg_op;
    logic [23:0]   cfg_qpn;
    logic [4:0]    cfg_len_log2;
    logic [31:0]   cfg_num_req;
    logic [AW-1:0] cfg_laddr_base, cfg_raddr_base;
    logic          tvalid, tready, tlast;
    logic [MW-1:0] tdata;
    logic [MW/8-1:0] tkeep;
    logic          sts_valid, sts_ready;
    logic [SW-1:0] sts_data;
    logic [31:0]   stat_sent, stat_acked, stat_cycles;
    logic          stat_timeout, stat_spurious;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    bit auto_ack = 1'b0;
    bit man_beat = 1'b0;
    logic [MW-1:0] metas[$];
    int due[$];

    always #5 clk = ~clk;

    roce_req_gen #(
        .META_W(MW), .STATUS_W(SW), .ADDR_W(AW),
        .MAX_OUTSTANDING(2), .ADDR_WINDOW(4096), .RUN_CYCLES(100)
    ) dut (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start),
        .ap_idle(ap_idle), .ap_done(ap_done), .ap_ready(ap_ready),
        .cfg_op(cfg_op), .cfg_qpn(cfg_qpn), .cfg_len_log2(cfg_len_log2),
        .cfg_num_req(cfg_num_req), .cfg_laddr_base(cfg_laddr_base),
        .cfg_raddr_base(cfg_raddr_base),
        .m_axis_tx_meta_tvalid(tvalid), .m_axis_tx_meta_tready(tready),
        .m_axis_tx_meta_tdata(tdata), .m_axis_tx_meta_tkeep(tkeep),
        .m_axis_tx_meta_tlast(tlast),
        .s_axis_tx_status_tvalid(sts_valid), .s_axis_tx_status_tready(sts_ready),
        .s_axis_tx_status_tdata(sts_data),
        .stat_sent(stat_sent), .stat_acked(stat_acked), .stat_cycles(stat_cycles),
        .stat_timeout(stat_timeout), .stat_spurious(stat_spurious)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Record accepted metas and done pulses; schedule a status 3 cycles after each accept
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ap_done === 1'b1) done_cnt <= done_cnt + 1;
        if (tvalid === 1'b1 && tready === 1'b1) begin
            metas.push_back(tdata);
            if (auto_ack) due.push_back(cyc + 3);
        end
    end

    // Status driver
    initial begin
        bit hit;
        sts_valid = 1'b0;
        sts_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            hit = 1'b0;
            while (due.size() > 0 && due[0] <= cyc) begin
                void'(due.pop_front());
                hit = 1'b1;
            end
            sts_valid = hit | man_beat;
            sts_data  = {16{32'hDEAD_BEEF}};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat();
        man_beat = 1'b1;
        step();
        man_beat = 1'b0;
    endtask

    task automatic start(input logic [2:0] op, input logic [23:0] qpn,
                         input logic [4:0] lg, input logic [31:0] num,
                         input logic [AW-1:0] lb, input logic [AW-1:0] rb);
        cfg_op = op; cfg_qpn = qpn; cfg_len_log2 = lg;
        cfg_num_req = num; cfg_laddr_base = lb; cfg_raddr_base = rb;
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        cfg_op = 3'd7; cfg_qpn = 24'h0; cfg_len_log2 = 5'd3;
        cfg_num_req = 32'd1; cfg_laddr_base = '1; cfg_raddr_base = '1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (ap_done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_done"}, 64'(ap_done), 64'd1);
        chk({tag, "_idle"}, 64'(ap_idle), 64'd1);
        step();
        chk({tag, "_pulse"}, 64'(ap_done), 64'd0);
    endtask

    task automatic chk_meta(input string tag, input int idx, input logic [2:0] op,
                            input logic [AW-1:0] lb, input logic [AW-1:0] rb,
                            input logic [AW-1:0] off, input logic [31:0] len);
        logic [MW-1:0] d;
        logic [AW-1:0] el, er;
        logic [MW-156:0] hi;
        if (idx >= metas.size()) begin
            chk({tag, "_missing"}, 64'(metas.size()), 64'(idx + 1));
        end else begin
            d  = metas[idx];
            el = lb + off;
            er = rb + off;
            hi = d[MW-1:155];
            chk({tag, "_op"}, 64'(d[2:0]), 64'(op));
            chk({tag, "_la"}, 64'(d[74:27]), 64'(el));
            chk({tag, "_ra"}, 64'(d[122:75]), 64'(er));
            chk({tag, "_len"}, 64'(d[154:123]), 64'(len));
            chk({tag, "_hi"}, 64'(|hi), 64'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b, d0, n;
        logic [MW-1:0] hold;
        bit stable;
        logic [AW-1:0] wrap_off[6];
        logic [AW-1:0] bas_off[4];
        bas_off  = '{48'h0, 48'h400, 48'h800, 48'hC00};
        wrap_off = '{48'h0, 48'h400, 48'h800, 48'hC00, 48'h0, 48'h400};
        ap_start = 1'b0; tready = 1'b0;
        cfg_op = '0; cfg_qpn = '0; cfg_len_log2 = '0; cfg_num_req = '0;
        cfg_laddr_base = '0; cfg_raddr_base = '0;

        #12;
        chk("rst_idle", 64'(ap_idle), 64'd1);
        chk("rst_done", 64'(ap_done), 64'd0);
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tdata", 64'(|tdata), 64'd0);
        chk("rst_stats", 64'(|{stat_sent, stat_acked, stat_cycles, stat_timeout, stat_spurious}), 64'd0);
        #11 rst_n = 1'b1;
        step();
        chk("keep_ones", 64'(&tkeep), 64'd1);
        chk("tlast", 64'(tlast), 64'd1);
        chk("sts_ready", 64'(sts_ready), 64'd1);

        // Basic READ, remote base near the top of the address space to exercise wrap
        auto_ack = 1'b1; tready = 1'b1;
        b = metas.size(); d0 = done_cnt;
        start(3'd0, 24'h123456, 5'd10, 32'd4, 48'h0000_1000_0000, 48'hFFFF_FFFF_FF00);
        chk("c1_idle", 64'(ap_idle), 64'd0);
        chk("c1_tvalid", 64'(tvalid), 64'd0);
        step();
        chk("c2_tvalid", 64'(tvalid), 64'd1);
        wait_done("basic", 80);
        chk("basic_n", 64'(metas.size() - b), 64'd4);
        for (int i = 0; i < 4; i++)
            chk_meta("basic", b + i, 3'd0, 48'h0000_1000_0000, 48'hFFFF_FFFF_FF00,
                     bas_off[i], 32'd1024);
        chk("basic_sent", 64'(stat_sent), 64'd4);
        chk("basic_acked", 64'(stat_acked), 64'd4);
        chk("basic_to", 64'(stat_timeout), 64'd0);
        chk("basic_spur", 64'(stat_spurious), 64'd0);
        chk("basic_dcnt", 64'(done_cnt - d0), 64'd1);

        // Credit stall with two credits and manual status return
        auto_ack = 1'b0;
        repeat (2) step();
        b = metas.size(); d0 = done_cnt;
        start(3'd1, 24'hABCDEF, 5'd8, 32'd5, 48'h2000, 48'h3000);
        repeat (45) step();
        chk("stall_n", 64'(metas.size() - b), 64'd2);
        chk("stall_sent", 64'(stat_sent), 64'd2);
        for (int k = 0; k < 4; k++) begin
            beat();
            repeat (5) step();
        end
        chk("stall_n5", 64'(metas.size() - b), 64'd5);
        chk("stall_nodone", 64'(done_cnt - d0), 64'd0);
        chk("stall_busy", 64'(ap_idle), 64'd0);
        beat();
        wait_done("stall", 20);
        chk("stall_acked", 64'(stat_acked), 64'd5);
        chk_meta("stall4", b + 4, 3'd1, 48'h2000, 48'h3000, 48'h400, 32'd256);

        // Backpressure on a single request
        auto_ack = 1'b1; tready = 1'b0;
        b = metas.size();
        start(3'd0, 24'h000042, 5'd12, 32'd1, 48'h5000, 48'h6000);
        n = 0;
        while (tvalid !== 1'b1 && n < 5) begin step(); n++; end
        chk("bp_valid", 64'(tvalid), 64'd1);
        hold = tdata; stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (tvalid !== 1'b1 || tdata !== hold) stable = 1'b0;
        end
        chk("bp_stable", 64'(stable), 64'd1);
        chk("bp_sent0", 64'(stat_sent), 64'd0);
        tready = 1'b1;
        wait_done("bp", 40);
        chk("bp_sent", 64'(stat_sent), 64'd1);
        chk("bp_n", 64'(metas.size() - b), 64'd1);
        chk_meta("bp", b, 3'd0, 48'h5000, 48'h6000, 48'h0, 32'd4096);

        // Window wrap
        b = metas.size();
        start(3'd1, 24'h000777, 5'd10, 32'd6, 48'h10000, 48'h20000);
        wait_done("wrap", 90);
        chk("wrap_n", 64'(metas.size() - b), 64'd6);
        for (int i = 0; i < 6; i++)
            chk_meta("wrap", b + i, 3'd1, 48'h10000, 48'h20000, wrap_off[i], 32'd1024);

        // Length larger than the window keeps the offset at zero
        b = metas.size();
        start(3'd0, 24'h000001, 5'd13, 32'd2, 48'h40000, 48'h50000);
        wait_done("big", 60);
        chk_meta("big1", b + 1, 3'd0, 48'h40000, 48'h50000, 48'h0, 32'd8192);

        // Timeout with no status returned, then status in IDLE
        auto_ack = 1'b0;
        d0 = done_cnt;
        start(3'd0, 24'h000002, 5'd6, 32'd0, 48'h0, 48'h0);
        wait_done("tmo", 150);
        chk("tmo_flag", 64'(stat_timeout), 64'd1);
        chk("tmo_sent", 64'(stat_sent), 64'd2);
        chk("tmo_cycles", 64'(stat_cycles), 64'd100);
        chk("tmo_dcnt", 64'(done_cnt - d0), 64'd1);
        chk("spur_pre", 64'(stat_spurious), 64'd0);
        for (int k = 0; k < 3; k++) begin
            beat();
            step();
        end
        chk("spur_acked", 64'(stat_acked), 64'd2);
        chk("spur_flag", 64'(stat_spurious), 64'd1);

        // Asynchronous reset in the middle of a run
        tready = 1'b1;
        start(3'd1, 24'h000003, 5'd4, 32'd5, 48'h0, 48'h0);
        n = 0;
        while (stat_sent !== 32'd1 && n < 10) begin step(); n++; end
        chk("mr_sent1", 64'(stat_sent), 64'd1);
        tready = 1'b0;
        n = 0;
        while (tvalid !== 1'b1 && n < 10) begin step(); n++; end
        chk("mr_valid", 64'(tvalid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_tvalid", 64'(tvalid), 64'd0);
        chk("mr_tdata", 64'(|tdata), 64'd0);
        chk("mr_idle", 64'(ap_idle), 64'd1);
        chk("mr_stats", 64'(|{stat_sent, stat_acked, stat_cycles, stat_timeout, stat_spurious}), 64'd0);
        #10 rst_n = 1'b1;
        step();
        auto_ack = 1'b1; tready = 1'b1;
        b = metas.size();
        start(3'd1, 24'h000004, 5'd10, 32'd2, 48'h8000, 48'h9000);
        wait_done("mr_run", 40);
        chk("mr_run_sent", 64'(stat_sent), 64'd2);
        chk("mr_run_acked", 64'(stat_acked), 64'd2);
        chk_meta("mr_run1", b + 1, 3'd1, 48'h8000, 48'h9000, 48'h400, 32'd1024);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
